// File: rtl/sub_result_pipe.sv
// Registered subtractor output stage: O = I0 - I1 with borrow/zero/overflow flags,
// behind a valid/ready handshake with a 2-entry skid buffer and registered I_READY.
module sub_result_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_BORROW,
    output logic             O_ZERO,
    output logic             O_OVF,
    output logic             O_VALID,
    input  logic             O_READY
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic             borrow;
        logic             zero;
        logic             ovf;
        logic [WIDTH-1:0] diff;
    } res_t;

    // Borrow falls out of the extra top bit of a zero-extended subtraction.
    function automatic res_t sub_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t                    r;
        logic        [WIDTH:0]   wide;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        wide     = {1'b0, a} - {1'b0, b};
        sa       = $signed(a);
        sb       = $signed(b);
        r.diff   = wide[WIDTH-1:0];
        r.borrow = wide[WIDTH];
        r.zero   = (wide[WIDTH-1:0] == '0);
        r.ovf    = (sa[WIDTH-1] != sb[WIDTH-1]) && (wide[WIDTH-1] != sa[WIDTH-1]);
        return r;
    endfunction

    occ_t occ_p1;
    res_t res_p0;
    res_t main_p1;
    res_t skid_p1;
    logic i_ready_p1;
    logic vld_p1;
    logic accept;
    logic xfer;

    assign res_p0 = sub_flags(I0, I1);
    assign vld_p1 = (occ_p1 != EMPTY);
    assign accept = I_VALID && i_ready_p1;
    assign xfer   = vld_p1 && O_READY;

    // ---- stage p0 -> p1: occupancy FSM and MAIN entry ----
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            occ_p1     <= EMPTY;
            i_ready_p1 <= 1'b0;
            main_p1    <= '0;
        end else begin
            case (occ_p1)
                EMPTY: begin
                    i_ready_p1 <= 1'b1;
                    if (accept) begin
                        main_p1 <= res_p0;
                        occ_p1  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !xfer) begin
                        occ_p1     <= FULL;
                        i_ready_p1 <= 1'b0;
                    end else if (accept) begin
                        main_p1 <= res_p0;
                    end else if (xfer) begin
                        occ_p1 <= EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        main_p1    <= skid_p1;
                        occ_p1     <= ONE;
                        i_ready_p1 <= 1'b1;
                    end
                end
                default: begin
                    occ_p1     <= EMPTY;
                    i_ready_p1 <= 1'b0;
                end
            endcase
        end
    end

    // Skid data needs no reset: its validity is carried entirely by occ_p1.
    always_ff @(posedge CLK) begin
        if (occ_p1 == ONE && accept && !xfer) begin
            skid_p1 <= res_p0;
        end
    end

    assign I_READY  = i_ready_p1;
    assign O_VALID  = vld_p1;
    assign O        = main_p1.diff;
    assign O_BORROW = main_p1.borrow;
    assign O_ZERO   = main_p1.zero;
    assign O_OVF    = main_p1.ovf;

endmodule

// File: tb/tb_sub_result_pipe.sv
// Directed and scoreboard bench for sub_result_pipe (WIDTH=8).
module tb_sub_result_pipe;

    logic       clk;
    logic       rst_n;
    logic [7:0] i0;
    logic [7:0] i1;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] o;
    logic       o_borrow;
    logic       o_zero;
    logic       o_ovf;
    logic       o_valid;
    logic       o_ready;

    int checks = 0;
    int errors = 0;

    sub_result_pipe #(.WIDTH(8)) dut (
        .CLK(clk),
        .ASYNCRESETN(rst_n),
        .I0(i0),
        .I1(i1),
        .I_VALID(i_valid),
        .I_READY(i_ready),
        .O(o),
        .O_BORROW(o_borrow),
        .O_ZERO(o_zero),
        .O_OVF(o_ovf),
        .O_VALID(o_valid),
        .O_READY(o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {borrow, zero, ovf, diff}, overflow judged from the true signed difference.
    function automatic logic [10:0] exp_res(input logic [7:0] a, input logic [7:0] b);
        int         sd;
        logic [7:0] d;
        sd = int'($signed(a)) - int'($signed(b));
        d  = a - b;
        return {(a < b), (d == 8'h00), (sd > 127 || sd < -128), d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i0 = 8'h00; i1 = 8'h00;
        #3;
        checks++;
        if ({o_valid, i_ready, o_borrow, o_zero, o_ovf, o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b flags=%b%b%b o=%h, want all 0",
                     o_valid, i_ready, o_borrow, o_zero, o_ovf, o);
        end
        step();
        rst_n = 1'b1;
        checks++;
        if (i_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", i_ready);
        end
        step();
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b want 1", i_ready);
        end
        // Put one result in flight, then reset between edges.
        i0 = 8'h22; i1 = 8'h11; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o !== 8'h11) begin
            errors++;
            $display("FAIL midstream_load: got valid=%b o=%h want valid=1 o=11", o_valid, o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b0 || o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ready=%b o=%h want 0 0 00", o_valid, i_ready, o);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rerelease: got ready=%b valid=%b want 1 0", i_ready, o_valid);
        end
    endtask

    task automatic test_basic();
        o_ready = 1'b1;
        i0 = 8'h05; i1 = 8'h03; i_valid = 1'b1;
        step();
        i_valid = 1'b0; i0 = 'x; i1 = 'x;
        checks++;
        if ({o_valid, o_borrow, o_zero, o_ovf, o} !== {4'b1000, 8'h02}) begin
            errors++;
            $display("FAIL basic: got valid=%b b=%b z=%b v=%b o=%h want 1 0 0 0 02",
                     o_valid, o_borrow, o_zero, o_ovf, o);
        end
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got valid=%b want 0", o_valid);
        end
        i0 = 8'h00; i1 = 8'h00;
    endtask

    task automatic test_flags();
        logic [7:0]  a  [3];
        logic [7:0]  b  [3];
        logic [10:0] ex [3];
        a[0] = 8'h03; b[0] = 8'h05; ex[0] = {3'b100, 8'hFE};
        a[1] = 8'h80; b[1] = 8'h01; ex[1] = {3'b001, 8'h7F};
        a[2] = 8'h5A; b[2] = 8'h5A; ex[2] = {3'b010, 8'h00};
        o_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i0 = a[k]; i1 = b[k]; i_valid = 1'b1;
            step();
            i_valid = 1'b0;
            checks++;
            if (o_valid !== 1'b1 || {o_borrow, o_zero, o_ovf, o} !== ex[k]) begin
                errors++;
                $display("FAIL flags_%0d: got valid=%b bzv_o=%b_%h want 1 %b_%h",
                         k, o_valid, {o_borrow, o_zero, o_ovf}, o, ex[k][10:8], ex[k][7:0]);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [10:0] r1, r2, r3;
        r1 = exp_res(8'h10, 8'h01);
        r2 = exp_res(8'h01, 8'h10);
        r3 = exp_res(8'h7F, 8'hFF);
        o_ready = 1'b0;
        i0 = 8'h10; i1 = 8'h01; i_valid = 1'b1;
        step();
        i0 = 8'h01; i1 = 8'h10;
        step();
        checks++;
        if (i_ready !== 1'b0 || {o_borrow, o_zero, o_ovf, o} !== r1) begin
            errors++;
            $display("FAIL bp_full: got ready=%b out=%h want 0 %h", i_ready, {o_borrow, o_zero, o_ovf, o}, r1);
        end
        i0 = 8'h7F; i1 = 8'hFF;
        step();
        checks++;
        if (i_ready !== 1'b0 || o_valid !== 1'b1 || {o_borrow, o_zero, o_ovf, o} !== r1) begin
            errors++;
            $display("FAIL bp_hold: got ready=%b valid=%b out=%h want 0 1 %h",
                     i_ready, o_valid, {o_borrow, o_zero, o_ovf, o}, r1);
        end
        o_ready = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b1 || i_ready !== 1'b1 || {o_borrow, o_zero, o_ovf, o} !== r2) begin
            errors++;
            $display("FAIL bp_second: got valid=%b ready=%b out=%h want 1 1 %h",
                     o_valid, i_ready, {o_borrow, o_zero, o_ovf, o}, r2);
        end
        step();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || {o_borrow, o_zero, o_ovf, o} !== r3) begin
            errors++;
            $display("FAIL bp_third: got valid=%b out=%h want 1 %h", o_valid, {o_borrow, o_zero, o_ovf, o}, r3);
        end
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_streaming();
        logic [7:0]  a, b;
        logic [10:0] ex;
        int          bad;
        bad = 0;
        o_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            i0 = a; i1 = b; i_valid = 1'b1;
            step();
            ex = exp_res(a, b);
            checks++;
            if (o_valid !== 1'b1 || i_ready !== 1'b1 || {o_borrow, o_zero, o_ovf, o} !== ex) begin
                errors++;
                if (bad < 5)
                    $display("FAIL stream_%0d: got valid=%b ready=%b out=%h want 1 1 %h",
                             k, o_valid, i_ready, {o_borrow, o_zero, o_ovf, o}, ex);
                bad++;
            end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [10:0] q[$];
        logic [10:0] held;
        logic        prev_stall;
        logic        acc, xf;
        int          bad;
        bad = 0;
        prev_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if (o_valid !== (q.size() != 0) || i_ready !== (q.size() < 2)) begin
                errors++;
                if (bad < 5)
                    $display("FAIL rand_occ_%0d: got valid=%b ready=%b want %b %b",
                             c, o_valid, i_ready, (q.size() != 0), (q.size() < 2));
                bad++;
            end
            if (prev_stall) begin
                checks++;
                if ({o_borrow, o_zero, o_ovf, o} !== held) begin
                    errors++;
                    if (bad < 5)
                        $display("FAIL rand_stable_%0d: got %h want %h", c, {o_borrow, o_zero, o_ovf, o}, held);
                    bad++;
                end
            end
            if (!(i_valid && !i_ready)) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i0 = 8'($urandom); i1 = 8'($urandom);
            end
            o_ready = ($urandom_range(0, 2) != 0);
            acc = i_valid && i_ready;
            xf  = o_valid && o_ready;
            if (xf) begin
                checks++;
                if (q.size() == 0 || {o_borrow, o_zero, o_ovf, o} !== q[0]) begin
                    errors++;
                    if (bad < 5)
                        $display("FAIL rand_data_%0d: got %h want %h", c, {o_borrow, o_zero, o_ovf, o},
                                 (q.size() != 0) ? q[0] : 11'h0);
                    bad++;
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (acc) q.push_back(exp_res(i0, i1));
            prev_stall = o_valid && !o_ready;
            held = {o_borrow, o_zero, o_ovf, o};
            step();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            if (o_valid) begin
                checks++;
                if ({o_borrow, o_zero, o_ovf, o} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_drain: got %h want %h", {o_borrow, o_zero, o_ovf, o}, q[0]);
                end
                void'(q.pop_front());
            end
            step();
        end
        checks++;
        if (q.size() != 0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_final: got pending=%0d valid=%b want 0 0", q.size(), o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_backpressure();
        test_streaming();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
